// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver with a small receive FIFO.
// The line is resynchronized, each frame is sampled mid-bit, and completed
// bytes are queued; framing errors and FIFO overruns are held as sticky flags.
module uart_rx #(
    parameter int clks_per_bit = 172,
    parameter int fifo_depth   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_error,
    output logic       overrun,
    input  logic       clear
);

    localparam int CNT_W = $clog2(clks_per_bit + 1);
    localparam int PTR_W = $clog2(fifo_depth);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(clks_per_bit);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(clks_per_bit / 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             rx_p0;
    logic             rx_s;

    logic [7:0]       mem [fifo_depth];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             full;
    logic             pop;
    logic             push_evt;
    logic             frame_evt;
    logic             do_push;
    logic             overrun_evt;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_p0 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_p0 <= rx;
            rx_s  <= rx_p0;
        end
    end

    // Stop-bit sample point: a high line completes the byte, a low line is a framing error
    assign push_evt  = (state == STOP) && (cnt == CNT_FULL) && rx_s;
    assign frame_evt = (state == STOP) && (cnt == CNT_FULL) && !rx_s;

    // Frame decoder: qualify the start bit at mid-bit, then sample every full bit period
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            bit_idx <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_idx <= '0;
                    if (!rx_s) state <= START;
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= rx_s ? IDLE : BREAK;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                BREAK: begin
                    cnt <= '0;
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift register collects data bits LSB first; pure datapath, no reset needed
    always_ff @(posedge clock) begin
        if (state == DATA && cnt == CNT_FULL) shreg <= {rx_s, shreg[7:1]};
    end

    // FIFO status: the extra pointer bit separates full from empty
    assign data_valid  = (wr_ptr != rd_ptr);
    assign full        = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                         (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop         = data_valid && data_ready;
    assign do_push     = push_evt && (!full || pop);
    assign overrun_evt = push_evt && full && !pop;
    assign data        = data_valid ? mem[rd_ptr[PTR_W-1:0]] : 8'h00;

    // FIFO storage write; a slot freed by a same-cycle pop can be refilled at once
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= shreg;
    end

    // FIFO pointers; reset wins over any push or pop in the same cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W + 1)'(1);
            if (pop)     rd_ptr <= rd_ptr + (PTR_W + 1)'(1);
        end
    end

    // Sticky error flags; a new event in the same cycle as clear keeps the flag set
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_error <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            if (frame_evt)   frame_error <= 1'b1;
            else if (clear)  frame_error <= 1'b0;
            if (overrun_evt) overrun     <= 1'b1;
            else if (clear)  overrun     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into uart_rx with a queue-based scoreboard.
// Expected bytes are queued as frames are sent; a monitor pops and compares
// each byte the DUT hands over on a valid/ready handshake.
module tb_uart_rx;

    localparam int BIT_CLKS = 173;

    logic       clock;
    logic       reset;
    logic       rx;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       frame_error;
    logic       overrun;
    logic       clear;

    int         tests;
    int         fails;
    logic [7:0] exp_q [$];

    uart_rx dut (
        .clock       (clock),
        .reset       (reset),
        .rx          (rx),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .frame_error (frame_error),
        .overrun     (overrun),
        .clear       (clear)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pops the scoreboard whenever the DUT hands over a byte
    task automatic monitor();
        logic [7:0] e;
        forever begin
            @(negedge clock);
            if (!reset && data_valid && data_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got 0x%0h, expected none", data);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_data", {24'h0, data}, {24'h0, e});
                end
            end
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Called at posedge+1; drives one 8N1 frame followed by a short idle gap
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(BIT_CLKS);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cycles(BIT_CLKS);
        end
        rx = stop_bit;
        wait_cycles(BIT_CLKS);
        rx = 1'b1;
        wait_cycles(20);
    endtask

    task automatic drain();
        int n;
        n = 0;
        data_ready = 1'b1;
        while (data_valid && n < 20) begin
            wait_cycles(1);
            n++;
        end
        data_ready = 1'b0;
        check("drain_empty", {31'h0, data_valid}, 32'h0);
    endtask

    initial begin
        int cyc;
        tests      = 0;
        fails      = 0;
        reset      = 1'b1;
        rx         = 1'b1;
        data_ready = 1'b0;
        clear      = 1'b0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_valid", {31'h0, data_valid}, 32'h0);
        check("rst_data", {24'h0, data}, 32'h0);
        check("rst_ferr", {31'h0, frame_error}, 32'h0);
        check("rst_ovr", {31'h0, overrun}, 32'h0);
        @(posedge clock);
        #1 reset = 1'b0;
        wait_cycles(5);

        // 0x55 with latency measurement
        exp_q.push_back(8'h55);
        cyc = 0;
        fork
            send_byte(8'h55, 1'b1);
            begin
                while (cyc < 2000) begin
                    @(posedge clock);
                    cyc++;
                    @(negedge clock);
                    if (data_valid) break;
                end
            end
        join
        tests++;
        if (cyc < 1645 || cyc > 1647) begin
            fails++;
            $display("FAIL latency_55: got %0d cycles, expected 1645..1647", cyc);
        end
        check("data_55", {24'h0, data}, 32'h55);
        check("ferr_55", {31'h0, frame_error}, 32'h0);
        check("ovr_55", {31'h0, overrun}, 32'h0);
        drain();

        // Start-bit glitch of 40 clocks
        rx = 1'b0;
        wait_cycles(40);
        rx = 1'b1;
        wait_cycles(300);
        check("glitch_valid", {31'h0, data_valid}, 32'h0);
        check("glitch_ferr", {31'h0, frame_error}, 32'h0);
        check("glitch_ovr", {31'h0, overrun}, 32'h0);

        // Framing error on 0xA5, then recovery with 0x3C and clear
        send_byte(8'hA5, 1'b0);
        check("ferr_set", {31'h0, frame_error}, 32'h1);
        check("ferr_novalid", {31'h0, data_valid}, 32'h0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        check("after_ferr_valid", {31'h0, data_valid}, 32'h1);
        check("after_ferr_data", {24'h0, data}, 32'h3C);
        check("ferr_sticky", {31'h0, frame_error}, 32'h1);
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        check("ferr_cleared", {31'h0, frame_error}, 32'h0);
        drain();

        // Overrun: five bytes into a four-entry FIFO
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        check("ovr_set", {31'h0, overrun}, 32'h1);
        check("ovr_head", {24'h0, data}, 32'h01);
        drain();
        clear = 1'b1;
        wait_cycles(1);
        clear = 1'b0;
        check("ovr_cleared", {31'h0, overrun}, 32'h0);

        // Full FIFO with a pop on the push cycle: no overrun, new byte kept
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(8'(i));
            send_byte(8'(i), 1'b1);
        end
        exp_q.push_back(8'h05);
        fork
            send_byte(8'h05, 1'b1);
            begin
                wait_cycles(1646);
                data_ready = 1'b1;
                wait_cycles(1);
                data_ready = 1'b0;
            end
        join
        check("simul_ovr", {31'h0, overrun}, 32'h0);
        check("simul_head", {24'h0, data}, 32'h02);
        drain();

        // Reset mid-frame with stale byte and flags present
        send_byte(8'h77, 1'b1);
        send_byte(8'h00, 1'b0);
        check("pre_rst_ferr", {31'h0, frame_error}, 32'h1);
        fork
            send_byte(8'hFF, 1'b1);
            begin
                wait_cycles(BIT_CLKS * 5 + 86);
                reset = 1'b1;
                wait_cycles(1);
                reset = 1'b0;
            end
        join
        check("midrst_valid", {31'h0, data_valid}, 32'h0);
        check("midrst_data", {24'h0, data}, 32'h0);
        check("midrst_ferr", {31'h0, frame_error}, 32'h0);
        check("midrst_ovr", {31'h0, overrun}, 32'h0);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        check("post_rst_data", {24'h0, data}, 32'h81);
        drain();

        check("queue_empty", exp_q.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
